// File: rtl/speck_pkg.sv
// Shared SPECK32/64 constants, word type and the encrypt-core state encoding.
package speck_pkg;
  localparam int WORD_W       = 16;
  localparam int ALPHA        = 7;
  localparam int BETA         = 2;
  localparam int ROUNDS_32_64 = 22;
  localparam int CNT_W        = 5;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/speck32_encrypt_core_round.sv
// One combinational SPECK round: x' = ((x ROR 7) + y) ^ k; y' = (y ROL 2) ^ x'.
// The modular add is the 16-bit AOIG ripple adder below (carry-in 0, carry-out dropped).
module speck_aoig_add16
  import speck_pkg::*;
(
  input  word_t a,
  input  word_t b,
  output word_t sum
);
  logic carry;

  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < WORD_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      // AND-OR-invert-invert form of generate | (propagate & carry)
      carry  = ~(~(a[i] & b[i]) & ~((a[i] ^ b[i]) & carry));
    end
  end
endmodule

module speck_round
  import speck_pkg::*;
(
  input  word_t x_i,
  input  word_t y_i,
  input  word_t k_i,
  output word_t x_o,
  output word_t y_o
);
  word_t x_ror;
  word_t y_rol;
  word_t add_s;

  assign x_ror = (x_i >> ALPHA) | (x_i << (WORD_W - ALPHA));
  assign y_rol = (y_i << BETA) | (y_i >> (WORD_W - BETA));

  speck_aoig_add16 u_add (
    .a   (x_ror),
    .b   (y_i),
    .sum (add_s)
  );

  assign x_o = add_s ^ k_i;
  assign y_o = y_rol ^ x_o;
endmodule

// File: rtl/speck32_encrypt_core.sv
// Iterative SPECK32/64 encryptor: one data round and one key-schedule step per cycle.
// Handshake: start is taken in IDLE or DONE; done pulses one cycle with ct valid; busy marks RUN.
module speck32_encrypt_core
  import speck_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_32_64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [31:0] pt,
  output logic        busy,
  output logic        done,
  output logic [31:0] ct
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  word_t              x_q, x_d, y_q, y_d, k_q, k_d;
  word_t              l0_q, l0_d, l1_q, l1_d, l2_q, l2_d;
  logic [31:0]        ct_q, ct_d;
  logic               busy_q, busy_d, done_q, done_d;

  word_t rnd_x, rnd_y, l_new, k_next, round_idx;

  assign round_idx = WORD_W'(cnt_q);

  speck_round u_data (
    .x_i (x_q),
    .y_i (y_q),
    .k_i (k_q),
    .x_o (rnd_x),
    .y_o (rnd_y)
  );

  // Key schedule reuses the round with l0 as x, k as y and the index as key.
  speck_round u_key (
    .x_i (l0_q),
    .y_i (k_q),
    .k_i (round_idx),
    .x_o (l_new),
    .y_o (k_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    l0_d    = l0_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    ct_d    = ct_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          x_d     = pt[31:16];
          y_d     = pt[15:0];
          k_d     = key[15:0];
          l0_d    = key[31:16];
          l1_d    = key[47:32];
          l2_d    = key[63:48];
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        x_d  = rnd_x;
        y_d  = rnd_y;
        k_d  = k_next;
        l0_d = l1_q;
        l1_d = l2_q;
        l2_d = l_new;
        if (cnt_q == CNT_W'(ROUNDS - 1)) begin
          state_d = ST_DONE;
          ct_d    = {rnd_x, rnd_y};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      l0_q    <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      l0_q    <= l0_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      ct_q    <= ct_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ct   = ct_q;
endmodule

// File: tb/tb_speck32_encrypt_core.sv
// Scoreboard bench for speck32_encrypt_core: drivers queue expected ciphertexts,
// an independent monitor pops and compares on every done pulse.
module tb_speck32_encrypt_core;
  localparam int          ROUNDS  = 22;
  localparam logic [63:0] STD_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] STD_PT  = 32'h6574_694C;
  localparam logic [31:0] STD_CT  = 32'hA868_42F2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] key;
  logic [31:0] pt;
  logic        busy;
  logic        done;
  logic [31:0] ct;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  speck32_encrypt_core #(.ROUNDS(ROUNDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .pt    (pt),
    .busy  (busy),
    .done  (done),
    .ct    (ct)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference SPECK32/64 written from the published key-schedule recurrence.
  function automatic logic [31:0] speck_model(input logic [63:0] k_in, input logic [31:0] p_in);
    logic [15:0] x, y, k;
    logic [15:0] l[ROUNDS + 3];
    x = p_in[31:16];
    y = p_in[15:0];
    k = k_in[15:0];
    l[0] = k_in[31:16];
    l[1] = k_in[47:32];
    l[2] = k_in[63:48];
    for (int i = 0; i < ROUNDS; i++) begin
      x = ({x[6:0], x[15:7]} + y) ^ k;
      y = {y[13:0], y[15:14]} ^ x;
      l[i + 3] = (k + {l[i][6:0], l[i][15:7]}) ^ 16'(i);
      k = {k[13:0], k[15:14]} ^ l[i + 3];
    end
    return {x, y};
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("ct", ct, exp_q.pop_front());
    end
  end

  // Starts one block; returns at the done cycle (or after a cycle budget).
  task automatic run_block(input logic [63:0] k_in, input logic [31:0] p_in,
                           input logic [31:0] e, input bit hold, input bit jitter);
    int lat;
    bit busy_ok;
    key   = k_in;
    pt    = p_in;
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= ROUNDS + 10; n++) begin
      if (jitter) begin
        key = {$urandom, $urandom};
        pt  = $urandom;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    check("done_latency", 32'(lat), 32'(ROUNDS));
    check("busy_during_run", 32'(busy_ok), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    int n_sweep;
    logic [63:0] rk;
    logic [31:0] rp;
    rst = 1'b1; start = 1'b0; key = '0; pt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ct", ct, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Standard vector, then return to IDLE.
    run_block(STD_KEY, STD_PT, STD_CT, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("ct_held", ct, STD_CT);

    // start held high throughout RUN: exactly one done.
    d0 = done_cnt;
    run_block(STD_KEY, STD_PT, STD_CT, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_done_count", 32'(done_cnt - d0), 32'd1);

    // Back-to-back: second start issued in the DONE cycle.
    run_block(STD_KEY, STD_PT, STD_CT, 1'b0, 1'b0);
    run_block(STD_KEY, 32'h1234_ABCD, speck_model(STD_KEY, 32'h1234_ABCD), 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset after ten rounds aborts the block.
    d0 = done_cnt;
    key = STD_KEY; pt = 32'h0BAD_F00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ct", ct, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_block(STD_KEY, STD_PT, STD_CT, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_ct", ct, 32'd0);
    @(posedge clk); #1;
    check("rst_prio_still_idle", 32'(busy), 32'd0);

    // Inputs toggled during RUN must not disturb the captured block.
    for (int b = 0; b < 5; b++) begin
      rk = {$urandom, $urandom};
      rp = $urandom;
      run_block(rk, rp, speck_model(rk, rp), 1'b0, 1'b1);
    end
    @(posedge clk); #1;

    // Random sweep with random idle gaps (0 = back-to-back from DONE).
    d0 = done_cnt;
    n_sweep = 1000;
    for (int b = 0; b < n_sweep; b++) begin
      rk = {$urandom, $urandom};
      rp = $urandom;
      run_block(rk, rp, speck_model(rk, rp), 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    check("sweep_done_count", 32'(done_cnt - d0), 32'(n_sweep));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/speck32_encrypt_core.md
SPECK32_ENCRYPT_CORE -- requirements
Module: speck32_encrypt_core

Interface
REQ-001 Parameter ROUNDS, default 22, is the number of SPECK32/64 rounds executed per block.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: request to encrypt the values on key and pt.
REQ-005 Port key, input, 64 bits: master key {l2,l1,l0,k0}, with l2 in bits [63:48] and k0 in bits [15:0].
REQ-006 Port pt, input, 32 bits: plaintext {x,y}, with x in bits [31:16].
REQ-007 Port busy, output, 1 bit: high while rounds are in progress.
REQ-008 Port done, output, 1 bit: one-cycle pulse marking ct valid.
REQ-009 Port ct, output, 32 bits: ciphertext {x,y}, held until the next accepted start or reset.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 start SHALL be accepted only in IDLE or DONE; a start in DONE begins a new block with no idle cycle.
REQ-012 start SHALL be ignored while in RUN.
REQ-013 On accepting start, the block SHALL load x, y, k and l0..l2 from pt and key, clear the round counter, and enter RUN.
REQ-014 Each RUN cycle SHALL perform one round: x' = ((x ROR 7) + y) XOR k; y' = (y ROL 2) XOR x'.
REQ-015 In the same cycle, the key schedule SHALL compute lnew = (k + (l0 ROR 7)) XOR i, where i is the zero-extended round index; then k' = (k ROL 2) XOR lnew, and the l words shift (l0<=l1, l1<=l2, l2<=lnew).
REQ-016 All additions SHALL be mod 2^16 with carry-in 0; the carry-out SHALL be discarded.
REQ-017 After round index ROUNDS-1 is registered, the FSM SHALL enter DONE, and ct SHALL equal {x,y}.
REQ-018 If start is sampled at edge E0, rounds SHALL occur at edges E1..E_ROUNDS, and done SHALL be high for exactly the cycle after edge E_ROUNDS.
REQ-019 busy SHALL be high in RUN only, and low in IDLE and DONE.
REQ-020 If no start is present in DONE, the FSM SHALL return to IDLE next cycle.
REQ-021 ct SHALL update only when entering DONE; intermediate round values are never visible on ct.
REQ-022 The round counter SHALL be 5 bits wide and SHALL NOT wrap within a block.
REQ-023 key and pt SHALL be sampled only on the accepting edge; changes during RUN have no effect.

Reset
REQ-024 When rst is high at a clock edge, the FSM SHALL go to IDLE and busy, done, ct, the counter, x, y, k and l0..l2 SHALL all become 0.
REQ-025 Reset mid-RUN SHALL abort the block with no done pulse.
REQ-026 rst SHALL take priority over a simultaneous start.

Structure
REQ-027 A shared package speck_pkg SHALL hold WORD_W=16, ALPHA=7, BETA=2, ROUNDS_32_64=22 and the FSM state enumeration.
REQ-028 One combinational sub-module, speck_round, SHALL implement the round function of REQ-014.
REQ-029 speck_round SHALL be instantiated twice: once for data, and once for the key schedule with the round index as its key input.
REQ-030 The 16-bit modular addition inside speck_round SHALL use the team's 16-bit AOIG adder block.

Verification
REQ-031 Standard vector: key=64'h1918_1110_0908_0100, pt=32'h6574_694C, start pulsed once -> done exactly 22 cycles after the start edge, ct=32'hA868_42F2.
REQ-032 start re-asserted every cycle during RUN -> exactly one done pulse, ct unchanged from the standard vector, busy never drops early.
REQ-033 Second start in the DONE cycle with a new pt -> second done exactly 22 cycles later, ct matching the golden model, busy low for exactly one cycle between blocks.
REQ-034 rst asserted at round 10 -> all outputs 0 next cycle, no done pulse; a subsequent standard-vector start still yields 32'hA868_42F2.
REQ-035 key and pt toggled randomly during RUN -> ct still equals the golden-model result for the values captured at start.
REQ-036 Random key/pt sweep (1000 blocks) -> every ct matches the software SPECK32/64 model; done count equals accepted start count.
